// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// The decode unit uses the same Op constants.
package hilo_muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_step.sv
// One iteration of the mul/div datapath.
// acc = {rem_or_hi[W:0], lo_or_quot[W-1:0]}.
module muldiv_step
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  step_mode_e       mode,
    output logic [2*WIDTH:0] acc_next,
    output logic             q_bit
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Shift-add for multiply, restoring shift-subtract for divide.
    // In divide mode the LSB is left 0; the caller ORs in q_bit.
    always_comb begin
        addend  = acc[0] ? operand : '0;
        mul_sum = acc[2*WIDTH:WIDTH] + {1'b0, addend};
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, operand};
        q_bit   = 1'b0;
        acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
        if (mode == MODE_DIV) begin
            q_bit = ~diff[WIDTH+1];
            acc_next = {(q_bit ? diff[WIDTH:0] : rem_sh),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding HI/LO.
// One bit per cycle; stalls the pipeline while busy.
module hilo_muldiv_sequencer
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    output logic             Stall,
    output logic             HiLoWrite,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             DivByZero
);

    localparam int AW = 2 * WIDTH + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op_in;
    logic             start_ok;
    logic             sa_in, sb_in, dbz_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [AW-1:0]    step_acc;
    logic             step_q;
    step_mode_e       step_mode;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    // Decode an incoming instruction into magnitudes and sign flags.
    always_comb begin
        op_in    = op_e'(Op);
        start_ok = Start & ~Flush & (state_q == IDLE);
        sa_in    = op_is_signed(op_in) & OperandA[WIDTH-1];
        sb_in    = op_is_signed(op_in) & OperandB[WIDTH-1];
        mag_a    = sa_in ? -OperandA : OperandA;
        mag_b    = sb_in ? -OperandB : OperandB;
        dbz_in   = op_is_div(op_in) & (OperandB == '0);
    end

    assign step_mode = op_is_div(op_q) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc_q),
        .operand (opnd_q),
        .mode    (step_mode),
        .acc_next(step_acc),
        .q_bit   (step_q)
    );

    // Sign fixup of the finished magnitude result.
    always_comb begin
        prod = acc_q[2*WIDTH-1:0];
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (sign_a_q ^ sign_b_q) begin
            prod = -prod;
        end
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (dbz_q) begin
                res_lo = '1;
                res_hi = sign_a_q ? -quot : quot;
            end else begin
                res_lo = (sign_a_q ^ sign_b_q) ? -quot : quot;
                res_hi = sign_a_q ? -rem : rem;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next state; a zero divisor skips the RUN loop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = dbz_in ? FIX : RUN;
            RUN:  if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Flush) begin
            state_d = IDLE;
        end
    end

    // Datapath next values: latch, iterate, then capture HI/LO.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (start_ok) begin
            op_d     = op_in;
            sign_a_d = sa_in;
            sign_b_d = sb_in;
            dbz_d    = dbz_in;
            cnt_d    = CNT_W'(WIDTH);
            if (op_is_div(op_in)) begin
                acc_d  = {{(WIDTH+1){1'b0}}, mag_a};
                opnd_d = mag_b;
            end else begin
                acc_d  = {{(WIDTH+1){1'b0}}, mag_b};
                opnd_d = mag_a;
            end
        end else if (state_q == RUN) begin
            acc_d = step_acc | AW'(step_q);
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == FIX && !Flush) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    // Outputs; Stall is combinational on Start to hold the issuing cycle.
    always_comb begin
        Stall     = Start | (state_q == RUN) | (state_q == FIX);
        HiLoWrite = (state_q == DONE) & ~Flush;
        DivByZero = (state_q == DONE) & ~Flush & dbz_q;
        HiOut     = hi_q;
        LoOut     = lo_q;
    end

endmodule
